// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared run-control state encoding and PC reset constant
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_RESET = 0;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_prog_ctr.sv
// ============================================================================
// prog_ctr : T-bit program counter register with clear, load, increment, hold
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_ctr
  import fetch_unit_pkg::*;
#(
  parameter int T = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_inc,
  input  logic [T-1:0] i_load_val,
  output logic [T-1:0] o_pc
);

  logic [T-1:0] pc_d;
  logic [T-1:0] pc_q;

  // Clear wins over load, load over increment; otherwise the PC holds.
  always_comb begin
    pc_d = pc_q;
    if (i_clr) begin
      pc_d = T'(PC_RESET);
    end else if (i_load) begin
      pc_d = i_load_val;
    end else if (i_inc) begin
      pc_d = pc_q + T'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= T'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC / run-control stage; resolves branch and halt strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int T = 10,
  parameter int W = 8,
  parameter int C = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Done_in,
  input  logic         BranchEZ,
  input  logic         BranchNZ,
  input  logic         BranchAlways,
  input  logic [W-1:0] Target,
  input  logic [W-1:0] Cond,
  output logic [T-1:0] ProgCtr,
  output logic [T-1:0] ProgCtr_p1,
  output logic         Run,
  output logic         Done,
  output logic [C-1:0] CycleCount
);

  fetch_state_t state_d, state_q;
  logic [C-1:0] cc_d, cc_q;
  logic         run_d, run_q;
  logic         done_d, done_q;

  logic         cond_zero;
  logic         taken;
  logic         pc_clr, pc_load, pc_inc;
  logic [T-1:0] target_ext;

  assign cond_zero  = (Cond == '0);
  assign taken      = BranchAlways | (BranchEZ & cond_zero) | (BranchNZ & ~cond_zero);
  assign target_ext = T'(Target);

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    pc_clr  = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_clr = 1'b1;
        if (Start) begin
          state_d = RUN;
          cc_d    = '0;
        end
      end
      RUN: begin
        cc_d = (cc_q == '1) ? cc_q : cc_q + C'(1);
        // Halt outranks any branch: the PC freezes on the halting instruction.
        if (Done_in) begin
          state_d = DONE;
        end else if (taken) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          cc_d    = '0;
          pc_clr  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_clr  = 1'b1;
      end
    endcase
    run_d  = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cc_q    <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  prog_ctr #(
    .T(T)
  ) u_prog_ctr (
    .clk        (Clk),
    .rst_n      (Reset),
    .i_clr      (pc_clr),
    .i_load     (pc_load),
    .i_inc      (pc_inc),
    .i_load_val (target_ext),
    .o_pc       (ProgCtr)
  );

  assign ProgCtr_p1 = ProgCtr + T'(1);
  assign Run        = run_q;
  assign Done       = done_q;
  assign CycleCount = cc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : vector table plus scoreboarded hand sequences for fetch_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start, Done_in, BranchEZ, BranchNZ, BranchAlways;
  logic [7:0] Target, Cond;
  logic [9:0] ProgCtr, ProgCtr_p1, pc4, pc4_p1;
  logic       Run, Done, run4, done4;
  logic [15:0] CycleCount;
  logic [3:0]  cc4;

  int total = 0;
  int bad   = 0;
  int e_pc  = 0;
  int e_cc  = 0;

  typedef struct {
    logic       start, dn, ez, nz, al;
    logic [7:0] tgt, cond;
    logic [9:0] pc;
    logic       run, done;
    logic [15:0] cc;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[7];

  always #5 Clk = ~Clk;

  fetch_unit #(.T(10), .W(8), .C(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Done_in(Done_in),
    .BranchEZ(BranchEZ), .BranchNZ(BranchNZ), .BranchAlways(BranchAlways),
    .Target(Target), .Cond(Cond), .ProgCtr(ProgCtr), .ProgCtr_p1(ProgCtr_p1),
    .Run(Run), .Done(Done), .CycleCount(CycleCount)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  fetch_unit #(.T(10), .W(8), .C(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Done_in(Done_in),
    .BranchEZ(BranchEZ), .BranchNZ(BranchNZ), .BranchAlways(BranchAlways),
    .Target(Target), .Cond(Cond), .ProgCtr(pc4), .ProgCtr_p1(pc4_p1),
    .Run(run4), .Done(done4), .CycleCount(cc4)
  );

  function automatic vec_t mk(input int start, dn, ez, nz, al, tgt, cond,
                              input int pc, run, done, cc);
    vec_t v;
    v.start = start[0]; v.dn = dn[0]; v.ez = ez[0]; v.nz = nz[0]; v.al = al[0];
    v.tgt = tgt[7:0]; v.cond = cond[7:0];
    v.pc = pc[9:0]; v.run = run[0]; v.done = done[0]; v.cc = cc[15:0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    Start = v.start; Done_in = v.dn; BranchEZ = v.ez; BranchNZ = v.nz;
    BranchAlways = v.al; Target = v.tgt; Cond = v.cond;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"},   int'(ProgCtr), 0);
    check({tag, ".p1"},   int'(ProgCtr_p1), 1);
    check({tag, ".run"},  int'(Run), 0);
    check({tag, ".done"}, int'(Done), 0);
    check({tag, ".cc"},   int'(CycleCount), 0);
    check({tag, ".cc4"},  int'(cc4), 0);
  endtask

  // Drive now (away from the edge), queue the expectation, compare after the edge.
  task automatic step(input vec_t v, input string name);
    vec_t e;
    int   e4;
    drive(v);
    exp_q.push_back(v);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, ".queue_empty"}, 1, 0);
    end else begin
      e  = exp_q.pop_front();
      e4 = (int'(e.cc) > 15) ? 15 : int'(e.cc);
      check({name, ".pc"},   int'(ProgCtr), int'(e.pc));
      check({name, ".p1"},   int'(ProgCtr_p1), (int'(e.pc) + 1) % 1024);
      check({name, ".run"},  int'(Run), int'(e.run));
      check({name, ".done"}, int'(Done), int'(e.done));
      check({name, ".cc"},   int'(CycleCount), int'(e.cc));
      check({name, ".cc4"},  int'(cc4), e4);
      check({name, ".pc4"},  int'(pc4), int'(e.pc));
    end
  endtask

  task automatic run_plain(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      e_pc = (e_pc + 1) % 1024;
      e_cc = e_cc + 1;
      step(mk(0, 0, 0, 0, 0, 0, 0, e_pc, 1, 0, e_cc), name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                start dn ez nz al tgt   cond  pc     run done cc
    tbl[0] = mk(0, 0, 0, 1, 0, 8'h40, 8'h05, 10'h040, 1, 0, 5);
    tbl[1] = mk(0, 0, 0, 1, 0, 8'h40, 8'h00, 10'h041, 1, 0, 6);
    tbl[2] = mk(0, 0, 1, 0, 0, 8'h40, 8'h00, 10'h040, 1, 0, 7);
    tbl[3] = mk(0, 0, 1, 0, 0, 8'h40, 8'h01, 10'h041, 1, 0, 8);
    tbl[4] = mk(0, 0, 1, 0, 1, 8'h40, 8'h01, 10'h040, 1, 0, 9);
    tbl[5] = mk(0, 0, 1, 1, 0, 8'h20, 8'h00, 10'h020, 1, 0, 10);
    tbl[6] = mk(0, 0, 0, 0, 1, 8'h64, 8'h00, 10'd100,  1, 0, 11);

    Reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_reset_vals("reset");
    @(negedge Clk);
    Reset = 1'b1;

    step(mk(0, 0, 1, 1, 1, 8'h40, 0, 0, 0, 0, 0), "idle_branch");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "start");
    e_pc = 0; e_cc = 0;
    run_plain(3, "count");
    step(mk(1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 4), "start_in_run");

    for (int i = 0; i < 7; i++) step(tbl[i], $sformatf("tbl%0d", i));

    drive(mk(0, 0, 0, 0, 1, 8'h08, 0, 0, 0, 0, 0));
    #1;
    check("jal.p1", int'(ProgCtr_p1), 101);
    step(mk(0, 0, 0, 0, 1, 8'h08, 0, 8, 1, 0, 12), "jal");
    e_pc = 8; e_cc = 12;
    run_plain(10, "sat");
    step(mk(0, 1, 0, 0, 0, 0, 0, 18, 0, 1, 23), "halt1");

    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "restart1");
    e_pc = 0; e_cc = 0;
    run_plain(12, "to12");
    step(mk(0, 1, 0, 0, 1, 8'h40, 0, 12, 0, 1, 13), "done_prio");
    for (int i = 0; i < 5; i++)
      step(mk(0, 1, 1, 1, 1, 8'h40, 0, 12, 0, 1, 13), $sformatf("done_hold%0d", i));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "restart2");
    e_pc = 0; e_cc = 0;
    run_plain(37, "to37");

    #2;
    Reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    #2;
    Reset = 1'b1;
    step(mk(0, 0, 0, 0, 1, 8'h40, 0, 0, 0, 0, 0), "post_reset_idle");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "start2");
    e_pc = 0; e_cc = 0;
    run_plain(3, "count2");
    step(mk(0, 0, 0, 0, 1, 8'hFF, 0, 255, 1, 0, 4), "jump255");
    e_pc = 255; e_cc = 4;
    run_plain(768, "climb");
    check("wrap.pc_at_top", int'(ProgCtr), 1023);
    check("wrap.p1_at_top", int'(ProgCtr_p1), 0);
    run_plain(1, "wrap");
    check("wrap.pc_zero", int'(ProgCtr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
